// File: rtl/lowampa_capture_ctrl.sv
// Capture sequencer: arms the capture buffers, freezes them a programmable time after a trigger,
// waits for readout, then holds off. Optional trigger timestamp under LOWAMPA_CAPTURE_TIMESTAMP_EN.
module lowampa_capture_ctrl #(
  parameter int unsigned POST_BITS = 16,
  parameter int unsigned HOLD_BITS = 16,
  parameter int unsigned CNT_BITS  = 32
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 trigger_i,
  input  logic                 force_i,
  input  logic                 arm_i,
  input  logic                 abort_i,
  input  logic                 auto_rearm_i,
  input  logic                 capture_waiting_i,
  input  logic [POST_BITS-1:0] posttrig_len_i,
  input  logic [HOLD_BITS-1:0] holdoff_len_i,
  output logic                 capture_enable_o,
  output logic                 triggered_o,
  output logic [2:0]           state_o,
  output logic [CNT_BITS-1:0]  trig_count_o,
  output logic [CNT_BITS-1:0]  missed_count_o
`ifdef LOWAMPA_CAPTURE_TIMESTAMP_EN
  ,
  output logic [47:0]          timestamp_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_POST    = 3'd2,
    S_READOUT = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  state_t               state, state_nx;
  logic [POST_BITS-1:0] post_cnt, post_cnt_nx;
  logic [HOLD_BITS-1:0] hold_cnt, hold_cnt_nx;
  logic                 trig_q;
  logic                 ev;
  logic                 accept;
  logic                 miss;

  assign state_o = state;

  always_comb begin
    ev          = (trigger_i & ~trig_q) | force_i;
    accept      = (state == S_ARMED) & ev & ~abort_i;
    miss        = ev & (state != S_ARMED);
    state_nx    = state;
    post_cnt_nx = post_cnt;
    hold_cnt_nx = hold_cnt;
    if (abort_i) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (arm_i) state_nx = S_ARMED;
        end
        S_ARMED: begin
          if (ev) begin
            state_nx    = S_POST;
            post_cnt_nx = posttrig_len_i;
          end
        end
        S_POST: begin
          if (post_cnt == '0) state_nx = S_READOUT;
          else                post_cnt_nx = post_cnt - POST_BITS'(1);
        end
        S_READOUT: begin
          if (!capture_waiting_i) begin
            state_nx    = S_HOLDOFF;
            hold_cnt_nx = holdoff_len_i;
          end
        end
        S_HOLDOFF: begin
          if (hold_cnt == '0) state_nx = auto_rearm_i ? S_ARMED : S_IDLE;
          else                hold_cnt_nx = hold_cnt - HOLD_BITS'(1);
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // capture_enable_o is derived from the next state so it lines up with state_o
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state            <= S_IDLE;
      post_cnt         <= '0;
      hold_cnt         <= '0;
      trig_q           <= 1'b0;
      capture_enable_o <= 1'b0;
      triggered_o      <= 1'b0;
      trig_count_o     <= '0;
      missed_count_o   <= '0;
    end else begin
      state            <= state_nx;
      post_cnt         <= post_cnt_nx;
      hold_cnt         <= hold_cnt_nx;
      trig_q           <= trigger_i;
      capture_enable_o <= (state_nx == S_ARMED) || (state_nx == S_POST);
      triggered_o      <= accept;
      if (accept && (trig_count_o != '1))
        trig_count_o <= trig_count_o + CNT_BITS'(1);
      if (miss && (missed_count_o != '1))
        missed_count_o <= missed_count_o + CNT_BITS'(1);
    end
  end

`ifdef LOWAMPA_CAPTURE_TIMESTAMP_EN
  logic [47:0] cycle_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cycle_cnt   <= '0;
      timestamp_o <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 48'd1;
      if (accept) timestamp_o <= cycle_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_lowampa_capture_ctrl.sv
// Scoreboard bench for lowampa_capture_ctrl: stimulus pushes reference-model expectations,
// a negedge monitor pops and compares them. Honours LOWAMPA_CAPTURE_TIMESTAMP_EN.
module tb_lowampa_capture_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic             trig, frc, arm, abrt, arel, cwait;
  logic [15:0]      plen, hlen;
  logic             cap_en, trg_o;
  logic [2:0]       st_o;
  logic [CNT_W-1:0] tc_o, mc_o;
  logic [47:0]      ts_o;

  lowampa_capture_ctrl #(.POST_BITS(16), .HOLD_BITS(16), .CNT_BITS(CNT_W)) dut (
    .aclk(aclk), .aresetn(aresetn), .trigger_i(trig), .force_i(frc), .arm_i(arm),
    .abort_i(abrt), .auto_rearm_i(arel), .capture_waiting_i(cwait),
    .posttrig_len_i(plen), .holdoff_len_i(hlen),
    .capture_enable_o(cap_en), .triggered_o(trg_o), .state_o(st_o),
    .trig_count_o(tc_o), .missed_count_o(mc_o)
`ifdef LOWAMPA_CAPTURE_TIMESTAMP_EN
    , .timestamp_o(ts_o)
`endif
  );
`ifndef LOWAMPA_CAPTURE_TIMESTAMP_EN
  assign ts_o = '0;
`endif

  always #5 aclk = ~aclk;

  typedef struct {
    int unsigned cyc;
    int          st;
    bit          cap;
    bit          trg;
    int unsigned tc;
    int unsigned mc;
    longint unsigned ts;
  } exp_t;

  exp_t        sb[$];
  int unsigned cycle = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  // reference model: mode numbers are the published state codes
  int              m_mode, m_post, m_hold;
  bit              m_prev;
  int unsigned     m_tc, m_mc;
  longint unsigned m_ctr, m_ts;

  always @(posedge aclk) cycle++;

  always @(negedge aclk) begin
    while (sb.size() > 0 && sb[0].cyc <= cycle) begin
      exp_t e;
      bit   bad;
      e = sb.pop_front();
      bad = (int'(st_o) != e.st) || (cap_en != e.cap) || (trg_o != e.trg) ||
            (int'(tc_o) != int'(e.tc)) || (int'(mc_o) != int'(e.mc));
`ifdef LOWAMPA_CAPTURE_TIMESTAMP_EN
      bad = bad || (ts_o != e.ts[47:0]);
`endif
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL cycle%0d: got st=%0d cap=%0b trg=%0b tc=%0d mc=%0d ts=%0d, exp st=%0d cap=%0b trg=%0b tc=%0d mc=%0d ts=%0d",
                 e.cyc, st_o, cap_en, trg_o, tc_o, mc_o, ts_o,
                 e.st, e.cap, e.trg, e.tc, e.mc, e.ts);
      end
    end
  end

  task automatic model_reset();
    m_mode = 0; m_post = 0; m_hold = 0; m_prev = 0;
    m_tc = 0; m_mc = 0; m_ctr = 0; m_ts = 0;
  endtask

  // apply current inputs for one clock, predict the post-edge outputs, then clear pulses
  task automatic tick();
    bit   ev, acc;
    exp_t e;
    ev  = (trig && !m_prev) || frc;
    acc = (m_mode == 1) && ev && !abrt;
    if (acc) begin
      if (m_tc < CMAX) m_tc++;
      m_ts = m_ctr;
    end
    if (ev && m_mode != 1 && m_mc < CMAX) m_mc++;
    if (abrt) m_mode = 0;
    else begin
      case (m_mode)
        0: if (arm) m_mode = 1;
        1: if (ev) begin m_mode = 2; m_post = int'(plen); end
        2: if (m_post == 0) m_mode = 3; else m_post--;
        3: if (!cwait) begin m_mode = 4; m_hold = int'(hlen); end
        4: if (m_hold == 0) m_mode = arel ? 1 : 0; else m_hold--;
        default: m_mode = 0;
      endcase
    end
    m_prev = trig;
    m_ctr  = (m_ctr + 1) & 48'hFFFF_FFFF_FFFF;
    e.cyc = cycle + 1;
    e.st  = m_mode;
    e.cap = (m_mode == 1) || (m_mode == 2);
    e.trg = acc;
    e.tc  = m_tc;
    e.mc  = m_mc;
    e.ts  = m_ts;
    sb.push_back(e);
    @(posedge aclk);
    @(negedge aclk);
    #1;
    frc = 0; arm = 0; abrt = 0;
  endtask

  task automatic check_val(string name, longint unsigned got, longint unsigned want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, exp %0d", name, got, want);
    end
  endtask

  // asynchronous reset: outputs must clear without any clock edge
  task automatic do_reset();
    aresetn = 0;
    trig = 0; frc = 0; arm = 0; abrt = 0;
    #1;
    check_val("reset_state", st_o, 0);
    check_val("reset_cap", cap_en, 0);
    check_val("reset_trg", trg_o, 0);
    check_val("reset_tc", tc_o, 0);
    check_val("reset_mc", mc_o, 0);
    check_val("reset_ts", ts_o, 0);
    sb.delete();
    model_reset();
    @(posedge aclk);
    @(negedge aclk);
    #1;
    aresetn = 1;
  endtask

  initial begin
    trig = 0; frc = 0; arm = 0; abrt = 0; arel = 1; cwait = 1;
    plen = 16'd3; hlen = 16'd2;
    aresetn = 1;
    #2;
    do_reset();

    // basic capture, readout and auto re-arm
    arm = 1; tick(); tick();
    trig = 1; tick();
    trig = 0; repeat (5) tick();
    check_val("readout_after_post", st_o, 3);
    repeat (9) tick();
    cwait = 0; tick();
    repeat (4) tick();
    check_val("rearmed_cap", cap_en, 1);
    check_val("trig_count_1", tc_o, 1);

    // level held high in ARMED triggers once; edges outside ARMED are misses
    cwait = 1; plen = 16'd1; hlen = 16'd5;
    trig = 1; repeat (5) tick();
    trig = 0; tick();
    trig = 1; tick(); trig = 0; tick();
    cwait = 0; arel = 0; tick();
    trig = 1; tick(); trig = 0; tick();
    repeat (6) tick();
    trig = 1; tick(); trig = 0; tick();
    trig = 1; tick(); trig = 0; tick();
    check_val("missed_4", mc_o, 4);
    check_val("held_once", tc_o, 2);

    // abort beats a trigger edge in ARMED; force with edge counts once
    arm = 1; tick();
    abrt = 1; trig = 1; tick();
    trig = 0; tick();
    check_val("abort_tc", tc_o, 2);
    check_val("abort_mc", mc_o, 4);
    arm = 1; abrt = 1; tick();
    arm = 1; tick();
    frc = 1; trig = 1; tick();
    trig = 0; tick();
    check_val("force_edge_tc", tc_o, 3);

    // reset in the middle of POST
    plen = 16'd10; arm = 1; cwait = 1; tick();
    trig = 1; tick(); trig = 0; repeat (3) tick();
    do_reset();

    // saturation of the accepted-trigger counter
    arel = 1; plen = 16'd0; hlen = 16'd0; cwait = 0;
    arm = 1; tick();
    for (int i = 0; i < 20; i++) begin
      frc = 1; tick();
      repeat (3) tick();
    end
    check_val("trig_sat", tc_o, CMAX);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      trig  = ($urandom_range(0, 99) < 30);
      frc   = ($urandom_range(0, 99) < 5);
      arm   = ($urandom_range(0, 99) < 15);
      abrt  = ($urandom_range(0, 99) < 2);
      arel  = ($urandom_range(0, 99) < 70);
      cwait = ($urandom_range(0, 99) < 60);
      plen  = 16'($urandom_range(0, 7));
      hlen  = 16'($urandom_range(0, 7));
      tick();
    end
    trig = 0;
    tick(); tick();
    check_val("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
